// File: rtl/buff_rmw_client.sv
//------------------------------------------------------------------------------
// Module   : buff_rmw_client
// Brief    : Credit-gated read-modify-write requester for an indexed buffer.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module buff_rmw_client #(
  parameter int IDX_W        = 8,
  parameter int DATA_W       = 32,
  parameter int MAX_CREDITS  = 16,
  parameter int INIT_CREDITS = 0,
  parameter int ACK_TIMEOUT  = 64,
  localparam int c_cw        = $clog2(MAX_CREDITS + 1)
) (
  input  logic              AXI_ACLK,
  input  logic              AXI_ARESET,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [IDX_W-1:0]  cmd_idx,
  input  logic [DATA_W-1:0] cmd_delta,
  input  logic              cmd_shrink,
  input  logic              credit_valid,
  input  logic [7:0]        credit_out,
  output logic              credit_ready,
  output logic              read_idx_valid,
  output logic [IDX_W-1:0]  read_idx,
  input  logic              read_idx_ready,
  output logic              read_will_update,
  output logic              is_shrink,
  input  logic              read_data_valid,
  input  logic [DATA_W-1:0] read_data,
  output logic              read_data_ready,
  output logic              update_idx_valid,
  output logic [IDX_W-1:0]  update_idx,
  output logic              update_data_valid,
  output logic [DATA_W-1:0] update_data,
  input  logic              update_ready,
  input  logic              update_receive_ack,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  input  logic              rsp_ready,
  output logic [c_cw-1:0]   credits,
  output logic              ERROR
);

  localparam int c_tw = $clog2(ACK_TIMEOUT + 1);
  localparam int c_sw = ((c_cw > 8) ? c_cw : 8) + 2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_RDATA = 3'd2,
    S_UPD   = 3'd3,
    S_ACK   = 3'd4,
    S_RSP   = 3'd5
  } state_t;

  state_t              r_state;
  logic                r_live;
  logic [IDX_W-1:0]    r_idx;
  logic [DATA_W-1:0]   r_delta;
  logic                r_shrink;
  logic                r_read_idx_valid;
  logic                r_will_update;
  logic                r_is_shrink;
  logic                r_read_data_ready;
  logic                r_upd_valid;
  logic [DATA_W-1:0]   r_update_data;
  logic                r_rsp_valid;
  logic [c_tw-1:0]     r_timer;
  logic [c_cw-1:0]     r_credits;
  logic                r_error;

  logic                w_consume;
  logic [c_sw-1:0]     w_sum;
  logic                w_ovf;
  logic                w_timeout;

  // A single outstanding command means a consume never underflows the counter.
  assign w_consume = (r_state == S_REQ) && read_idx_ready && !r_shrink;
  assign w_sum     = c_sw'(r_credits)
                   + (credit_valid ? c_sw'(credit_out) : c_sw'(0))
                   - (w_consume ? c_sw'(1) : c_sw'(0));
  assign w_ovf     = w_sum > c_sw'(MAX_CREDITS);
  assign w_timeout = (r_state == S_ACK) && !update_receive_ack
                   && (r_timer == c_tw'(ACK_TIMEOUT - 1));

  assign cmd_ready = (r_state == S_IDLE) && r_live
                   && (!cmd_valid || cmd_shrink || (r_credits != '0));

  always_ff @(posedge AXI_ACLK) begin
    if (AXI_ARESET) begin
      r_state           <= S_IDLE;
      r_live            <= 1'b0;
      r_idx             <= '0;
      r_delta           <= '0;
      r_shrink          <= 1'b0;
      r_read_idx_valid  <= 1'b0;
      r_will_update     <= 1'b0;
      r_is_shrink       <= 1'b0;
      r_read_data_ready <= 1'b0;
      r_upd_valid       <= 1'b0;
      r_update_data     <= '0;
      r_rsp_valid       <= 1'b0;
      r_timer           <= '0;
      r_credits         <= c_cw'(INIT_CREDITS);
      r_error           <= 1'b0;
    end else begin
      r_live    <= 1'b1;
      r_credits <= w_ovf ? c_cw'(MAX_CREDITS) : w_sum[c_cw-1:0];
      r_error   <= r_error | w_ovf | w_timeout;

      case (r_state)
        S_IDLE: begin
          if (cmd_valid && cmd_ready) begin
            r_idx            <= cmd_idx;
            r_delta          <= cmd_delta;
            r_shrink         <= cmd_shrink;
            r_read_idx_valid <= 1'b1;
            r_will_update    <= !cmd_shrink;
            r_is_shrink      <= cmd_shrink;
            r_state          <= S_REQ;
          end
        end
        S_REQ: begin
          if (read_idx_ready) begin
            r_read_idx_valid <= 1'b0;
            if (r_shrink) begin
              r_state <= S_IDLE;
            end else begin
              r_read_data_ready <= 1'b1;
              r_state           <= S_RDATA;
            end
          end
        end
        S_RDATA: begin
          if (read_data_valid) begin
            r_read_data_ready <= 1'b0;
            r_update_data     <= read_data + r_delta;
            r_upd_valid       <= 1'b1;
            r_state           <= S_UPD;
          end
        end
        S_UPD: begin
          if (update_ready) begin
            r_upd_valid <= 1'b0;
            r_timer     <= '0;
            r_state     <= S_ACK;
          end
        end
        S_ACK: begin
          // On timeout the consumed credit is deliberately left unreturned.
          if (update_receive_ack) begin
            r_rsp_valid <= 1'b1;
            r_state     <= S_RSP;
          end else if (w_timeout) begin
            r_state <= S_IDLE;
          end else begin
            r_timer <= r_timer + c_tw'(1);
          end
        end
        S_RSP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign credit_ready      = r_live;
  assign read_idx_valid    = r_read_idx_valid;
  assign read_idx          = r_idx;
  assign read_will_update  = r_will_update;
  assign is_shrink         = r_is_shrink;
  assign read_data_ready   = r_read_data_ready;
  assign update_idx_valid  = r_upd_valid;
  assign update_idx        = r_idx;
  assign update_data_valid = r_upd_valid;
  assign update_data       = r_update_data;
  assign rsp_valid         = r_rsp_valid;
  assign rsp_data          = r_update_data;
  assign credits           = r_credits;
  assign ERROR             = r_error;

endmodule

`default_nettype wire
